// File: rtl/axis_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : axis_serial_rx
// Description : Oversampling serial-to-AXI-Stream receiver. Takes a 1-bit
//               line that has already been synchronised into i_new_clk,
//               recovers start/data/stop framing (LSB first) and presents
//               each received word on an AXIS master port with a one-deep
//               output register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_new_clk      in   1       receive clock, rising edge
//   i_reset_n      in   1       asynchronous, active-low reset
//   i_serial_sync  in   1       synchronised serial line, idles high
//   m_axis_tdata   out  DATA_W  received word
//   m_axis_tvalid  out  1       word valid
//   m_axis_tready  in   1       downstream ready
//   o_frame_err    out  1       one-cycle pulse: stop bit sampled low
//   o_overrun      out  1       one-cycle pulse: word dropped, output full
// ============================================================================
module axis_serial_rx #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              i_new_clk,
    input  logic              i_reset_n,
    input  logic              i_serial_sync,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Tick values one cycle before a sample point: the counter is cleared on
    // the edge that enters a state, so the sample edge sees N-1.
    localparam logic [TICK_W-1:0] C_HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] C_FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  C_LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_prev;
    logic                r_armed;
    logic [TICK_W-1:0]   r_tick;
    logic [BIT_W-1:0]    r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic                r_done_good;
    logic                r_done_bad;

    logic [DATA_W-1:0]   r_tdata;
    logic                r_tvalid;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_fall;
    logic [DATA_W:0]     w_cat;
    logic [DATA_W-1:0]   w_shift_next;

    // The previous-sample register resets high, so a line that is already low
    // when reset releases would look like a falling edge. r_armed requires the
    // line to have been seen high at least once before a frame may start.
    assign w_fall       = r_armed & r_prev & ~i_serial_sync;

    // New bit enters at the MSB and moves down; after DATA_W shifts the first
    // received bit sits in the LSB.
    assign w_cat        = {i_serial_sync, r_shift};
    assign w_shift_next = w_cat[DATA_W:1];

    // ------------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge i_new_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_prev      <= 1'b1;
            r_armed     <= 1'b0;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_done_good <= 1'b0;
            r_done_bad  <= 1'b0;
        end else begin
            r_prev      <= i_serial_sync;
            r_done_good <= 1'b0;
            r_done_bad  <= 1'b0;
            if (i_serial_sync) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end
                end

                S_START: begin
                    if (r_tick == C_HALF_LAST) begin
                        r_tick  <= '0;
                        // A line back high mid-start-bit is a glitch.
                        r_state <= i_serial_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_tick == C_FULL_LAST) begin
                        r_tick  <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit == C_LAST_BIT) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_tick == C_FULL_LAST) begin
                        r_tick      <= '0;
                        r_done_good <= i_serial_sync;
                        r_done_bad  <= ~i_serial_sync;
                        r_state     <= i_serial_sync ? S_IDLE : S_BREAK;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                // Line stuck low after a bad stop bit: wait for it to return
                // high so the next genuine falling edge starts a new frame.
                S_BREAK: begin
                    if (i_serial_sync) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register and status pulses. Completion is acted on one cycle
    // after the stop-bit sample. A handshake on that same edge frees the slot,
    // so the new word loads and tvalid stays high without an overrun.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_new_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= r_done_bad;
            r_overrun   <= 1'b0;
            if (r_done_good) begin
                if (r_tvalid && !m_axis_tready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_tdata  <= r_shift;
                    r_tvalid <= 1'b1;
                end
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign o_frame_err   = r_frame_err;
    assign o_overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_axis_serial_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axis_serial_rx
// Description : Self-checking bench for axis_serial_rx. Frames are driven
//               bit-by-bit on the serial line; expected words are queued when
//               a frame is sent and popped on each AXIS transfer. Timing of
//               tvalid / frame_err / overrun is checked against the cycle the
//               falling edge was presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_serial_rx;

    localparam int DATA_W = 8;
    localparam int OS     = 16;
    localparam int LAT    = OS / 2 + OS * (DATA_W + 1) + 1;   // 153

    logic              clk;
    logic              rst_n;
    logic              line;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              ferr;
    logic              ovr;

    axis_serial_rx #(
        .DATA_W     (DATA_W),
        .OVERSAMPLE (OS)
    ) u_dut (
        .i_new_clk     (clk),
        .i_reset_n     (rst_n),
        .i_serial_sync (line),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .o_frame_err   (ferr),
        .o_overrun     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] sb[$];

    int   n_rise = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0;
    int   rise_cyc = -1, ferr_cyc = -1, ovr_cyc = -1;
    logic last_tvalid = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_word;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    int r0, v0, f0, o0, t0, t1, t2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Runs at the negedge: inputs and outputs are both stable here.
    task automatic monitor();
        logic [DATA_W-1:0] exp;
        if (!rst_n) begin
            last_tvalid = tvalid;
            return;
        end
        if (tvalid && tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got tdata %0h required no transfer", tdata);
            end else begin
                exp = sb.pop_front();
                check("xfer_tdata", {24'd0, tdata}, {24'd0, exp});
            end
        end
        if (tvalid) n_vcyc++;
        if (tvalid && !last_tvalid) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (ferr) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (ovr) begin
            n_ovr++;
            ovr_cyc = cyc;
        end
        if (ferr || ovr) check("flags_exclusive", {31'd0, ferr & ovr}, 32'd0);
        last_tvalid = tvalid;
    endtask

    // One clock: monitor at negedge, then return 2ns after the next posedge.
    // cyc holds the index of the most recent rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drives start, DATA_W data bits (LSB first) and the stop bit. t0 is the
    // edge index where the falling edge is seen (cycle 0). If rdy_rel >= 0,
    // tready is high only for the edge at that relative cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rdy_rel,
                              output int t0_o);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0_o = cyc + 1;
        for (int b = 0; b < 10; b++) begin
            line = bits[b];
            for (int k = 0; k < OS; k++) begin
                if (rdy_rel >= 0) tready = ((cyc + 1 - t0_o) == rdy_rel);
                step();
            end
        end
    endtask

    task automatic snap();
        r0 = n_rise; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_word: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_word: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_word: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h5A, stop: 1'b1, exp_word: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_word: 1'b0, exp_ferr: 1'b1};

        rst_n  = 1'b0;
        line   = 1'b1;
        tready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata",  {24'd0, tdata},  32'd0);
        check("rst_ferr",   {31'd0, ferr},   32'd0);
        check("rst_ovr",    {31'd0, ovr},    32'd0);
        #1 rst_n = 1'b1;
        idle(5);

        // Table-driven single frames, tready held high.
        tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            snap();
            if (vecs[i].exp_word) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, -1, t0);
            tready = 1'b1;
            line   = 1'b1;
            idle(20);
            check("vec_rise_cnt", n_rise - r0, {31'd0, vecs[i].exp_word});
            check("vec_valid_cycles", n_vcyc - v0, {31'd0, vecs[i].exp_word});
            check("vec_ferr_cnt", n_ferr - f0, {31'd0, vecs[i].exp_ferr});
            check("vec_ovr_cnt", n_ovr - o0, 32'd0);
            if (vecs[i].exp_word) check("vec_rise_cyc", rise_cyc - t0, LAT);
            if (vecs[i].exp_ferr) check("vec_ferr_cyc", ferr_cyc - t0, LAT);
            check("vec_sb_empty", sb.size(), 32'd0);
        end

        // Start-bit glitch: low 5 cycles then high; nothing may come out.
        snap();
        line = 1'b0;
        idle(5);
        line = 1'b1;
        idle(180);
        check("glitch_rise", n_rise - r0, 32'd0);
        check("glitch_ferr", n_ferr - f0, 32'd0);
        check("glitch_ovr",  n_ovr - o0,  32'd0);

        // Bad stop bit, line held low 40 more cycles, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0, -1, t0);
        tready = 1'b1;
        idle(40);
        line = 1'b1;
        idle(20);
        check("break_ferr_cyc", ferr_cyc - t0, LAT);
        check("break_ferr_cnt", n_ferr - f0, 32'd1);
        check("break_no_word", n_rise - r0, 32'd0);
        sb.push_back(8'h01);
        send_frame(8'h01, 1'b1, -1, t0);
        tready = 1'b1;
        idle(10);
        check("after_break_rise_cyc", rise_cyc - t0, LAT);
        check("after_break_sb", sb.size(), 32'd0);

        // Backpressure overrun: 0x11 held, 0x22 dropped.
        tready = 1'b0;
        idle(5);
        snap();
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, t1);
        send_frame(8'h22, 1'b1, -1, t2);
        idle(5);
        check("ovr_cyc", ovr_cyc - t2, LAT);
        check("ovr_cnt", n_ovr - o0, 32'd1);
        check("ovr_rise_cyc", rise_cyc - t1, LAT);
        check("ovr_rise_cnt", n_rise - r0, 32'd1);
        check("ovr_hold_tvalid", {31'd0, tvalid}, 32'd1);
        check("ovr_hold_tdata", {24'd0, tdata}, 32'h11);
        tready = 1'b1;
        idle(30);
        check("ovr_drained_tvalid", {31'd0, tvalid}, 32'd0);
        check("ovr_sb_empty", sb.size(), 32'd0);

        // tready raised exactly on the completion edge of the second word.
        tready = 1'b0;
        idle(5);
        snap();
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, t1);
        sb.push_back(8'h22);
        send_frame(8'h22, 1'b1, LAT, t2);
        check("same_cycle_ovr", n_ovr - o0, 32'd0);
        check("same_cycle_rise_cnt", n_rise - r0, 32'd1);
        check("same_cycle_tvalid", {31'd0, tvalid}, 32'd1);
        check("same_cycle_tdata", {24'd0, tdata}, 32'h22);
        check("same_cycle_sb", sb.size(), 32'd1);
        tready = 1'b1;
        idle(5);
        check("same_cycle_sb_drained", sb.size(), 32'd0);

        // Asynchronous reset mid-DATA with a held word in the output register.
        tready = 1'b0;
        send_frame(8'h99, 1'b1, -1, t0);
        idle(3);
        line = 1'b0; idle(OS);
        line = 1'b1; idle(OS);
        line = 1'b0; idle(20);
        #1 rst_n = 1'b0;
        line = 1'b1;
        #1;
        check("async_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("async_rst_tdata",  {24'd0, tdata},  32'd0);
        check("async_rst_ferr",   {31'd0, ferr},   32'd0);
        check("async_rst_ovr",    {31'd0, ovr},    32'd0);
        idle(3);
        #1 rst_n = 1'b1;
        tready = 1'b1;
        idle(10);
        snap();
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1, t0);
        tready = 1'b1;
        idle(10);
        check("post_rst_rise_cyc", rise_cyc - t0, LAT);
        check("post_rst_rise_cnt", n_rise - r0, 32'd1);
        check("post_rst_flags", (n_ferr - f0) + (n_ovr - o0), 32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
